// File: rtl/player_health_pkg.sv
// Shared types and constants for the player health controller.
//   HP_W      - hit-point width
//   BAR_W     - health-bar pixel width
//   TIMER_W   - invincibility countdown width (centi-second ticks)
//   health_state_t - controller states IDLE/ALIVE/INVULN/DEAD (0..3)
//   bar_width()    - hp * pixels-per-hp, truncated to the bar width
package player_health_pkg;

    localparam int unsigned HP_W    = 7;
    localparam int unsigned BAR_W   = 10;
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } health_state_t;

    function automatic logic [BAR_W-1:0] bar_width(input logic [HP_W-1:0] hp_v,
                                                   input int unsigned     per_hp);
        logic [31:0] prod;
        prod = 32'(hp_v) * per_hp;
        return prod[BAR_W-1:0];
    endfunction

endpackage

// File: rtl/player_health_if.sv
// Signal bundle between the trigger stage / UI / game manager and the
// player health controller.
//   game_start, centi_tick, hit, hit_damage : into the controller
//   hp, health_bar_w, invulnerable, damage_pulse, game_over : out of it
// master = surrounding system, slave = controller.
interface player_health_if;
    import player_health_pkg::*;

    logic              game_start;
    logic              centi_tick;
    logic              hit;
    logic [HP_W-1:0]   hit_damage;
    logic [HP_W-1:0]   hp;
    logic [BAR_W-1:0]  health_bar_w;
    logic              invulnerable;
    logic              damage_pulse;
    logic              game_over;

    modport master (
        output game_start, centi_tick, hit, hit_damage,
        input  hp, health_bar_w, invulnerable, damage_pulse, game_over
    );

    modport slave (
        input  game_start, centi_tick, hit, hit_damage,
        output hp, health_bar_w, invulnerable, damage_pulse, game_over
    );

endinterface

// File: rtl/player_health_cs_countdown.sv
// Centi-second countdown used for the invincibility window.
//   clk, reset  - clock, synchronous active-low reset
//   clear       - force timer to 0 (highest priority)
//   load        - load load_value (beats tick in the same cycle)
//   tick        - decrement by one, stopping at 0
//   timer       - current count
//   expired     - combinational: the tick that finds timer==1
import player_health_pkg::*;

module cs_countdown (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    output logic [TIMER_W-1:0] timer,
    output logic               expired
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (load) begin
            timer <= load_value;
        end else if (tick && (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    assign expired = (timer == TIMER_W'(1)) && tick;

endmodule

// File: rtl/player_health_controller.sv
// Owns the player's hit points: applies per-hit damage, holds an
// invincibility window after each hit and declares game over.
//   clk, reset - clock, synchronous active-low reset
//   bus.game_start   - pulse, (re)start round at full HP
//   bus.centi_tick   - 10 ms pulse
//   bus.hit          - level, player overlaps a damaging object
//   bus.hit_damage   - damage of that object
//   bus.hp           - current hit points (registered)
//   bus.health_bar_w - hp * BAR_W_PER_HP (registered with hp)
//   bus.invulnerable - high in INVULN
//   bus.damage_pulse - one cycle per applied hit
//   bus.game_over    - high in DEAD
import player_health_pkg::*;

module player_health_controller #(
    parameter int unsigned HP_MAX       = 100,
    parameter int unsigned INVULN_CS    = 50,
    parameter int unsigned BAR_W_PER_HP = 2
) (
    input  logic               clk,
    input  logic               reset,
    player_health_if.slave     bus
);

    localparam logic [HP_W-1:0]    HP_FULL   = HP_W'(HP_MAX);
    localparam logic [BAR_W-1:0]   BAR_FULL  = bar_width(HP_FULL, BAR_W_PER_HP);
    localparam logic [TIMER_W-1:0] WINDOW_CS = TIMER_W'(INVULN_CS);

    health_state_t      state_q;
    logic [HP_W-1:0]    hp_q;
    logic [BAR_W-1:0]   bar_q;
    logic               invul_q;
    logic               pulse_q;
    logic               over_q;

    logic [HP_W-1:0]    hp_sub;
    logic               apply_hit;
    logic               tick_en;
    logic [TIMER_W-1:0] timer;
    logic               expired;

    always_comb begin
        hp_sub    = (hp_q > bus.hit_damage) ? (hp_q - bus.hit_damage) : '0;
        // game_start outranks a hit arriving in the same cycle
        apply_hit = (state_q == ALIVE) && bus.hit && (bus.hit_damage != '0)
                    && !bus.game_start;
        // the timer only counts inside the window
        tick_en   = bus.centi_tick && (state_q == INVULN);
    end

    cs_countdown u_countdown (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.game_start),
        .load       (apply_hit),
        .load_value (WINDOW_CS),
        .tick       (tick_en),
        .timer      (timer),
        .expired    (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hp_q    <= HP_FULL;
            bar_q   <= BAR_FULL;
            invul_q <= 1'b0;
            pulse_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.game_start) begin
                state_q <= ALIVE;
                hp_q    <= HP_FULL;
                bar_q   <= BAR_FULL;
                invul_q <= 1'b0;
                over_q  <= 1'b0;
            end else begin
                case (state_q)
                    ALIVE: begin
                        if (apply_hit) begin
                            hp_q    <= hp_sub;
                            bar_q   <= bar_width(hp_sub, BAR_W_PER_HP);
                            pulse_q <= 1'b1;
                            if (hp_sub == '0) begin
                                state_q <= DEAD;
                                over_q  <= 1'b1;
                            end else begin
                                state_q <= INVULN;
                                invul_q <= 1'b1;
                            end
                        end
                    end
                    INVULN: begin
                        if (expired) begin
                            state_q <= ALIVE;
                            invul_q <= 1'b0;
                        end
                    end
                    IDLE, DEAD: ;
                endcase
            end
        end
    end

    assign bus.hp           = hp_q;
    assign bus.health_bar_w = bar_q;
    assign bus.invulnerable = invul_q;
    assign bus.damage_pulse = pulse_q;
    assign bus.game_over    = over_q;

    // timer value itself is only observed through expired
    logic unused_timer;
    assign unused_timer = ^timer;

endmodule

// File: doc/player_health_controller.md
# player_health_controller

Consumes the per-frame player-hit flag from the multi-object trigger runtime and owns the player's hit points. Applies per-hit damage, enforces an invincibility window counted in centi-second ticks, and declares game over. Feeds the game UI runtime, which draws the health bar, and the game manager, which halts on game over. Sits directly downstream of the trigger stage.

## Interface
- HP_MAX, 100: starting and maximum hit points; must be ≤ 127.
- INVULN_CS, 50: invincibility length in centi-second ticks, 1..255.
- BAR_W_PER_HP, 2: health-bar pixels per HP; HP_MAX*BAR_W_PER_HP must be ≤ 1023.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- game_start  in  1  one-cycle pulse; (re)starts a round at full HP.
- centi_tick  in  1  one-cycle pulse every 10 ms, from the shared centi-second divider.
- hit  in  1  level; high while the player overlaps a damaging object (is_trigger_player).
- hit_damage  in  7  damage of the overlapping object; valid when hit=1.
- hp  out  7  current hit points.
- health_bar_w  out  10  hp*BAR_W_PER_HP, for the UI bar.
- invulnerable  out  1  high in INVULN.
- damage_pulse  out  1  one-cycle pulse on every applied hit.
- game_over  out  1  high in DEAD.

## Operation
- States: IDLE, ALIVE, INVULN, DEAD.
- Reset (reset=0): state IDLE, hp=HP_MAX, health_bar_w=HP_MAX*BAR_W_PER_HP, timer=0, invulnerable=0, damage_pulse=0, game_over=0.
- Any state with game_start=1: go to ALIVE, hp=HP_MAX, timer=0. game_start has priority over hit and centi_tick in the same cycle.
- IDLE: ignore hit and centi_tick.
- ALIVE with hit=1 and hit_damage≠0:
  - hp_next = (hp > hit_damage) ? hp − hit_damage : 0. Saturating; never wraps.
  - Assert damage_pulse.
  - If hp_next=0, go to DEAD. Otherwise go to INVULN with timer=INVULN_CS.
- ALIVE with hit=1 and hit_damage=0: no effect.
- INVULN:
  - hit ignored.
  - Each centi_tick decrements timer.
  - A tick that finds timer=1 returns to ALIVE with timer=0. The window is exactly INVULN_CS ticks.
  - If hit is still high on the first ALIVE cycle, damage applies again.
- DEAD: hp=0, game_over=1. Only game_start leaves DEAD.
- health_bar_w is always registered in the same cycle as hp, using the product hp*BAR_W_PER_HP truncated to 10 bits. The parameter constraint guarantees no truncation.

## Timing
- All outputs are registered.
- hit sampled at edge N → hp, health_bar_w, state outputs and damage_pulse valid after edge N. Latency is 1 cycle.
- damage_pulse is high for exactly one cycle per applied hit.
- At most one hit is applied per INVULN window.
- A continuously high hit in ALIVE yields one hit, then one more hit every INVULN_CS ticks plus 1 cycle.
- A centi_tick arriving in the same cycle as a hit applied in ALIVE does not decrement the freshly loaded timer.
- Reset mid-window or mid-DEAD returns to IDLE immediately, with the full reset values above.

## Structure
- Package player_health_pkg holds:
  - state encoding (2-bit localparams IDLE=0, ALIVE=1, INVULN=2, DEAD=3);
  - HP width (7) and bar width (10) constants.
- Sub-module cs_countdown holds the 8-bit timer, with load, tick and expired. expired is combinational: timer=1 && tick.
- The top holds the FSM, the saturating subtractor and the bar multiply.

## Test plan
- Reset, then game_start, then one-cycle hit with hit_damage=30 → next cycle hp=70, health_bar_w=140, damage_pulse=1 for 1 cycle, invulnerable=1.
- hit held high for 120 centi_ticks with damage 10 and INVULN_CS=50 → exactly 3 hits applied; hp 100→90→80→70; damage_pulse count = 3.
- hp=5, hit_damage=20 → hp=0, game_over=1, invulnerable=0. Further hits and ticks cause no change.
- In DEAD, game_start asserted with hit=1 in the same cycle → ALIVE, hp=100, no damage_pulse.
- In INVULN with timer=30, reset=0 for one cycle → IDLE, hp=100, all flags 0. Afterwards hit is ignored until game_start.
- hit=1 with hit_damage=0 in ALIVE → hp unchanged, no damage_pulse, state stays ALIVE.
